uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and bit-timing helpers
package uart_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int baud_half(input int clk_freq, input int baud);
        return baud_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter that ticks once per loaded period
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load period-1 so the tick lands exactly load_val cycles later; otherwise count down and park at zero
    always_comb begin
        cnt_d = load ? load_val - CNT_W'(1) : (cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1));
    end

    // Counter register
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

    assign tick = cnt_q == '0;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ready output register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int RX_BAUD  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV  = baud_div(CLK_FREQ, RX_BAUD);
    localparam int HALF = baud_half(CLK_FREQ, RX_BAUD);

    uart_state_e      state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d, data_q, data_d;
    logic             valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic             rx_s, tick, baud_load, done, load_out;
    logic [CNT_W-1:0] baud_val;

    assign rx_s = sync2_q;

    uart_baud_cnt u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (baud_load),
        .load_val (baud_val),
        .tick     (tick)
    );

    // Two-flop synchronizer plus a delayed copy of rx_s for falling-edge detection, idle-high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame FSM: half-period wait to mid-start, then one sample per bit period; stop sample ends the frame
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        baud_load   = 1'b0;
        baud_val    = CNT_W'(DIV);
        done        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: if (prev_q && !rx_s) begin
                state_d   = START;
                bit_cnt_d = '0;
                baud_load = 1'b1;
                baud_val  = CNT_W'(HALF);
            end
            START: if (tick) begin
                state_d   = rx_s ? IDLE : DATA;
                baud_load = !rx_s;
            end
            DATA: if (tick) begin
                shift_d   = {rx_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                baud_load = 1'b1;
                state_d   = bit_cnt_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_d     = IDLE;
                done        = rx_s;
                frame_err_d = !rx_s;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a completed byte loads only when the slot is free, otherwise it is dropped as an overrun
    always_comb begin
        load_out  = done && (!valid_q || ready);
        valid_d   = load_out || (valid_q && !ready);
        data_d    = load_out ? shift_q : data_q;
        overrun_d = done && valid_q && !ready;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a cycle-timing model of the receiver
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int RX_BAUD  = 100_000;
    localparam int DIV      = 16;
    localparam int HALF     = 8;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .RX_BAUD(RX_BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = 0, fe_cnt = 0, ov_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] dut_q[$], m_q[$];

    logic m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1, m_busy = 1'b0;
    int m_t0 = 0;
    logic [7:0] m_byte = 8'h00, exp_data = 8'h00;
    logic exp_valid = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame timing as arithmetic on the cycle number of the rx_s falling edge
    task automatic model_update();
        logic rs, done;
        int d;
        if (!rst && exp_valid && ready) m_q.push_back(exp_data);
        if (!rst && prev_valid && ready) dut_q.push_back(prev_data);
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1; m_busy = 1'b0;
            exp_valid = 1'b0; exp_data = 8'h00; exp_fe = 1'b0; exp_ov = 1'b0;
        end else begin
            rs = m_s2;
            done = 1'b0;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            if (m_busy) begin
                d = cyc - m_t0;
                if (d == HALF && rs) m_busy = 1'b0;
                else if (d > HALF && d < HALF + 9 * DIV && (d - HALF) % DIV == 0)
                    m_byte[(d - HALF) / DIV - 1] = rs;
                else if (d == HALF + 9 * DIV) begin
                    m_busy = 1'b0;
                    done = rs;
                    exp_fe = !rs;
                end
            end else if (m_prev && !rs) begin
                m_busy = 1'b1;
                m_t0 = cyc;
            end
            if (done) begin
                if (!exp_valid || ready) begin
                    exp_data = m_byte;
                    exp_valid = 1'b1;
                end else exp_ov = 1'b1;
            end else if (exp_valid && ready) exp_valid = 1'b0;
            m_prev = rs;
            m_s2 = m_s1;
            m_s1 = rx;
        end
    endtask

    // One clock: advance the model, then compare every DUT output against it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        chk("valid", valid, exp_valid);
        chk("frame_err", frame_err, exp_fe);
        chk("overrun", overrun, exp_ov);
        if (exp_valid) chk("data", data, exp_data);
        if (!rst && frame_err) fe_cnt++;
        if (!rst && overrun) ov_cnt++;
        if (valid && !prev_valid) rise_cyc = cyc;
        prev_valid = valid;
        prev_data = data;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(DIV);
        end
        rx = stop;
        wait_cyc(DIV);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] f0;
        int fe0, ov0, n0;
        f0 = 8'hF0;
        wait_cyc(5);
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        ready = 1'b1;
        wait_cyc(10);

        send(8'hA5, 1'b1);
        wait_cyc(20);
        chk("a5_count", dut_q.size(), 1);
        chk("a5_data", dut_q.size() > 0 ? int'(dut_q[0]) : -1, 8'hA5);
        chk("a5_model", m_q.size() > 0 ? int'(m_q[0]) : -1, 8'hA5);
        chk("a5_frame_err", fe_cnt, 0);
        chk("a5_latency", rise_cyc - start_cyc, 155);

        dut_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
        wait_cyc(20);
        chk("seq_count", dut_q.size(), 256);
        for (int i = 0; i < dut_q.size() && i < 256; i++) chk("seq_byte", dut_q[i], i);
        chk("seq_overrun", ov_cnt, 0);
        chk("seq_frame_err", fe_cnt, 0);

        ready = 1'b0;
        dut_q.delete();
        ov_cnt = 0;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        wait_cyc(5);
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h3C);
        chk("ovr_pulses", ov_cnt, 1);
        ready = 1'b1;
        step();
        chk("ovr_valid_drop", valid, 0);
        chk("ovr_count", dut_q.size(), 1);
        chk("ovr_byte", dut_q.size() > 0 ? int'(dut_q[0]) : -1, 8'h3C);

        dut_q.delete();
        fe_cnt = 0;
        send(8'h55, 1'b0);
        wait_cyc(DIV);
        chk("ferr_pulses", fe_cnt, 1);
        chk("ferr_valid", valid, 0);
        chk("ferr_count", dut_q.size(), 0);

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        n0 = dut_q.size();
        rx = 1'b0;
        wait_cyc(HALF - 2);
        rx = 1'b1;
        wait_cyc(3 * DIV);
        chk("glitch_frame_err", fe_cnt, fe0);
        chk("glitch_overrun", ov_cnt, ov0);
        chk("glitch_count", dut_q.size(), n0);
        chk("glitch_valid", valid, 0);

        dut_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        rx = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            wait_cyc(DIV);
        end
        rx = f0[4];
        wait_cyc(HALF);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(5 * DIV);
        chk("rst_no_valid", dut_q.size(), 0);
        send(8'h0F, 1'b1);
        wait_cyc(DIV);
        chk("rst_count", dut_q.size(), 1);
        chk("rst_byte", dut_q.size() > 0 ? int'(dut_q[0]) : -1, 8'h0F);
        chk("rst_frame_err", fe_cnt, 0);
        chk("rst_overrun", ov_cnt, 0);

        dut_q.delete();
        fe_cnt = 0;
        rx = 1'b0;
        wait_cyc(30 * DIV);
        chk("break_frame_err", fe_cnt, 1);
        chk("break_valid", dut_q.size(), 0);
        rx = 1'b1;
        wait_cyc(2 * DIV);
        send(8'h81, 1'b1);
        wait_cyc(DIV);
        chk("break_recover", dut_q.size() > 0 ? int'(dut_q[0]) : -1, 8'h81);
        chk("break_frame_err_total", fe_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
